alu_share_arbiter: RTL and testbench

// Shares one combinational WIDTH-bit ALU (AND/OR/ADD/SUB, carry out) between two requesters.

---
 rtl/alu_share_arbiter.sv | 152 +++++++++++++++
 tb/tb_alu_share_arbiter.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter
//   Shares one external combinational ALU (AND/OR/ADD/SUB with carry out)
//   between two requesters. Arbitration is round-robin, and only one
//   operation is in flight at a time. Operands, opcode and results are all
//   registered.
//
// Ports
//   clk, rst                       clock and synchronous active-high reset
//   req0_* / req1_*                requester channels (valid/ready, a, b, op)
//                                  op encoding: 00 AND, 01 OR, 10 ADD, 11 SUB
//   alu_a, alu_b, alu_op           registered operands/opcode driven to the ALU
//   alu_out, alu_carry             combinational ALU result fed back
//   rsp_valid/rsp_ready            response handshake
//   rsp_id, rsp_result, rsp_carry  captured response fields
//   busy                           high while an operation is in EXEC or RESP
module alu_share_arbiter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [1:0]       req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [1:0]       req1_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [1:0]       alu_op,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_carry,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_carry,
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic             prio_q, prio_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d;
  logic [WIDTH-1:0] alu_b_q, alu_b_d;
  logic [1:0]       alu_op_q, alu_op_d;
  logic             rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
  logic             rsp_carry_q, rsp_carry_d;
  logic             grant0, grant1;

  // Grant decode. Readies are held low during reset so that nothing is
  // accepted on the reset edge, even though the state register still
  // shows its pre-reset value.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state_q == S_IDLE && !rst) begin
      if (req0_valid && req1_valid) begin
        grant0 = ~prio_q;
        grant1 = prio_q;
      end else begin
        grant0 = req0_valid;
        grant1 = req1_valid;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    prio_d       = prio_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_op_d     = alu_op_q;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    rsp_carry_d  = rsp_carry_q;
    case (state_q)
      S_IDLE: begin
        if (grant1) begin
          alu_a_d  = req1_a;
          alu_b_d  = req1_b;
          alu_op_d = req1_op;
          rsp_id_d = 1'b1;
          state_d  = S_EXEC;
        end else if (grant0) begin
          alu_a_d  = req0_a;
          alu_b_d  = req0_b;
          alu_op_d = req0_op;
          rsp_id_d = 1'b0;
          state_d  = S_EXEC;
        end
      end
      S_EXEC: begin
        // ALU inputs have been stable for a full cycle; sample its output.
        rsp_result_d = alu_out;
        rsp_carry_d  = alu_carry;
        state_d      = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) begin
          // The requester just served drops to low priority.
          prio_d  = ~rsp_id_q;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      prio_q       <= 1'b0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_op_q     <= 2'b00;
      rsp_id_q     <= 1'b0;
      rsp_result_q <= '0;
      rsp_carry_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      prio_q       <= prio_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_op_q     <= alu_op_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
      rsp_carry_q  <= rsp_carry_d;
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_op     = alu_op_q;
  assign rsp_valid  = (state_q == S_RESP);
  assign rsp_id     = rsp_id_q;
  assign rsp_result = rsp_result_q;
  assign rsp_carry  = rsp_carry_q;
  assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Testbench for alu_share_arbiter: directed scenarios followed by random
// traffic. A behavioural ALU drives alu_out/alu_carry. The monitor predicts
// grants, busy and response timing from the arbitration rules, and a queue
// of expected responses is checked whenever the DUT presents one.
module tb_alu_share_arbiter;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         req0_valid, req0_ready, req1_valid, req1_ready;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [1:0]   req0_op, req1_op;
  logic [W-1:0] alu_a, alu_b, alu_out;
  logic [1:0]   alu_op;
  logic         alu_carry;
  logic         rsp_valid, rsp_ready, rsp_id, rsp_carry, busy;
  logic [W-1:0] rsp_result;

  always #5 clk = ~clk;

  alu_share_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_out(alu_out), .alu_carry(alu_carry),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_result(rsp_result),
    .rsp_carry(rsp_carry), .busy(busy)
  );

  // Attached ALU (SUB reports the borrow as its carry bit).
  always_comb begin
    case (alu_op)
      2'b00:   {alu_carry, alu_out} = {1'b0, alu_a & alu_b};
      2'b01:   {alu_carry, alu_out} = {1'b0, alu_a | alu_b};
      2'b10:   {alu_carry, alu_out} = {1'b0, alu_a} + {1'b0, alu_b};
      default: {alu_carry, alu_out} = {1'b0, alu_a} - {1'b0, alu_b};
    endcase
  end

  typedef struct {
    int id;
    int res;
    int cy;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad = 0;
  int n_rsp = 0;
  int m_busy = 0;
  int m_prio = 0;
  int m_age = 0;
  int m_a = 0, m_b = 0, m_op = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference ALU arithmetic on plain integers.
  function automatic exp_t model(input int id, input int a, input int b, input int op);
    exp_t e;
    int s;
    e.id = id;
    case (op)
      0: begin e.res = a & b; e.cy = 0; end
      1: begin e.res = a | b; e.cy = 0; end
      2: begin s = a + b; e.res = s % (1 << W); e.cy = (s >= (1 << W)) ? 1 : 0; end
      default: begin s = a - b; e.res = (s + (1 << W)) % (1 << W); e.cy = (s < 0) ? 1 : 0; end
    endcase
    return e;
  endfunction

  // Monitor / scoreboard, sampled on the falling edge.
  always @(negedge clk) begin
    int e0, e1;
    exp_t e;
    if (rst) begin
      chk("rdy0_in_rst", 32'(req0_ready), 0);
      chk("rdy1_in_rst", 32'(req1_ready), 0);
      m_busy = 0; m_prio = 0; m_age = 0;
      m_a = 0; m_b = 0; m_op = 0;
      q.delete();
    end else begin
      if (m_busy != 0) m_age++;
      e0 = 0;
      e1 = 0;
      if (m_busy == 0) begin
        if (req0_valid && req1_valid) begin
          if (m_prio != 0) e1 = 1; else e0 = 1;
        end else if (req0_valid) e0 = 1;
        else if (req1_valid) e1 = 1;
      end
      chk("req0_ready", 32'(req0_ready), 32'(e0));
      chk("req1_ready", 32'(req1_ready), 32'(e1));
      chk("busy", 32'(busy), 32'(m_busy));
      chk("rsp_valid", 32'(rsp_valid), (m_busy != 0 && m_age >= 2) ? 1 : 0);
      if (m_busy == 0) begin
        chk("alu_a_hold", 32'(alu_a), 32'(m_a));
        chk("alu_b_hold", 32'(alu_b), 32'(m_b));
        chk("alu_op_hold", 32'(alu_op), 32'(m_op));
      end
      if (rsp_valid) begin
        if (q.size() == 0) begin
          chk("rsp_unexpected", 1, 0);
        end else begin
          chk("rsp_id", 32'(rsp_id), 32'(q[0].id));
          chk("rsp_result", 32'(rsp_result), 32'(q[0].res));
          chk("rsp_carry", 32'(rsp_carry), 32'(q[0].cy));
          if (rsp_ready) begin
            $display("resp   id=%0d result=%0d carry=%0d", rsp_id, rsp_result, rsp_carry);
            m_prio = (q[0].id == 0) ? 1 : 0;
            void'(q.pop_front());
            m_busy = 0;
            n_rsp++;
          end
        end
      end
      if (e0 != 0 || e1 != 0) begin
        if (e1 != 0) begin
          m_a = int'(req1_a); m_b = int'(req1_b); m_op = int'(req1_op);
        end else begin
          m_a = int'(req0_a); m_b = int'(req0_b); m_op = int'(req0_op);
        end
        e = model(e1, m_a, m_b, m_op);
        q.push_back(e);
        $display("accept id=%0d a=%0d b=%0d op=%0d", e1, m_a, m_b, m_op);
        m_busy = 1;
        m_age = 0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input int n, input int a, input int b, input int op);
    bit got;
    got = 1'b0;
    if (n == 0) begin
      req0_a = 4'(a); req0_b = 4'(b); req0_op = 2'(op); req0_valid = 1'b1;
    end else begin
      req1_a = 4'(a); req1_b = 4'(b); req1_op = 2'(op); req1_valid = 1'b1;
    end
    for (int i = 0; i < 30 && !got; i++) begin
      @(negedge clk);
      if ((n == 0 && req0_ready) || (n == 1 && req1_ready)) got = 1'b1;
    end
    if (!got) chk("issue_timeout", 0, 1);
    step();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      step();
      if (!busy) done = 1'b1;
    end
    if (!done) chk("idle_timeout", 0, 1);
  endtask

  initial begin
    rst = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = '0; req0_b = '0; req0_op = '0;
    req1_a = '0; req1_b = '0; req1_op = '0;
    rsp_ready = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    step();

    // Basic operations.
    issue(0, 3, 5, 2);    wait_idle();
    issue(1, 15, 1, 2);   wait_idle();
    issue(1, 12, 10, 0);  wait_idle();
    issue(1, 12, 10, 1);  wait_idle();
    issue(0, 2, 7, 3);    wait_idle();

    // Both requesters valid continuously: grants alternate.
    req0_a = 4'd1; req0_b = 4'd2; req0_op = 2'd2; req0_valid = 1'b1;
    req1_a = 4'd7; req1_b = 4'd9; req1_op = 2'd3; req1_valid = 1'b1;
    repeat (12) step();
    req0_valid = 1'b0; req1_valid = 1'b0;
    wait_idle();

    // Response back-pressure with a competing request pending.
    rsp_ready = 1'b0;
    issue(0, 9, 9, 2);
    req1_valid = 1'b1;
    repeat (7) step();
    req1_valid = 1'b0;
    rsp_ready = 1'b1;
    wait_idle();

    // Reset while in EXEC; priority must return to requester 0.
    issue(0, 4, 4, 2);
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1;
    step();
    req0_valid = 1'b0; req1_valid = 1'b0;
    wait_idle();

    // Requester 1 alone, back-to-back.
    req1_a = 4'd5; req1_b = 4'd6; req1_op = 2'd2; req1_valid = 1'b1;
    repeat (10) step();
    req1_valid = 1'b0;
    wait_idle();

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      req0_valid = ($urandom_range(3) != 0);
      req1_valid = ($urandom_range(3) != 0);
      req0_a = 4'($urandom); req0_b = 4'($urandom); req0_op = 2'($urandom);
      req1_a = 4'($urandom); req1_b = 4'($urandom); req1_op = 2'($urandom);
      rsp_ready = ($urandom_range(9) < 7);
      rst = ($urandom_range(79) == 0);
      step();
    end
    rst = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    rsp_ready = 1'b1;
    repeat (6) step();

    chk("queue_drained", 32'(q.size()), 0);
    chk("rsp_seen", (n_rsp > 20) ? 1 : 0, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
